// File: rtl/fetch_unit_if.sv
// Fetch unit bus: redirect input, instruction-memory request/response
// channel and the fetched-instruction output toward decode.
interface fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            i_b_taken;
    logic [XLEN-1:0] i_b_pc;
    logic            mem_req;
    logic [XLEN-1:0] mem_addr;
    logic            i_mem_gnt;
    logic            i_mem_rvalid;
    logic [31:0]     i_val_from_mem_ctr;
    logic            valid;
    logic            i_ready;
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic [XLEN-1:0] pc_next;

    modport slave (
        input  i_b_taken, i_b_pc,
        input  i_mem_gnt, i_mem_rvalid, i_val_from_mem_ctr,
        input  i_ready,
        output mem_req, mem_addr,
        output valid, pc, inst, pc_next
    );

    modport master (
        output i_b_taken, i_b_pc,
        output i_mem_gnt, i_mem_rvalid, i_val_from_mem_ctr,
        output i_ready,
        input  mem_req, mem_addr,
        input  valid, pc, inst, pc_next
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: in-order request stream into a circular buffer,
// with redirect flushing and discard tracking of in-flight responses.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    fetch_unit_if.slave io_bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    logic [XLEN-1:0] r_fetch_pc;
    ptr_t            r_alloc_ptr;
    ptr_t            r_fill_ptr;
    ptr_t            r_rd_ptr;
    cnt_t            r_alloc_cnt;
    cnt_t            r_pend_cnt;
    cnt_t            r_discard;
    logic [XLEN-1:0] r_slot_pc   [DEPTH];
    logic [31:0]     r_slot_inst [DEPTH];
    logic [DEPTH-1:0] r_slot_filled;

    logic [CW:0] w_occ;
    logic        w_room;
    logic        w_head_ok;
    logic        w_grant;
    logic        w_pop;
    logic        w_drop;
    logic        w_fill;
    logic        w_charge;
    cnt_t        w_redir_disc;

    // Occupancy counts only registered state, so pops never reach mem_req.
    assign w_occ  = {1'b0, r_alloc_cnt} + {1'b0, r_discard};
    assign w_room = w_occ < (CW+1)'(DEPTH);

    assign io_bus.mem_req  = !i_rst && !io_bus.i_b_taken && w_room;
    assign io_bus.mem_addr = r_fetch_pc;

    assign w_head_ok = (r_alloc_cnt != '0) && r_slot_filled[r_rd_ptr];

    assign io_bus.valid   = w_head_ok && !io_bus.i_b_taken && !i_rst;
    assign io_bus.pc      = r_slot_pc[r_rd_ptr];
    assign io_bus.inst    = r_slot_inst[r_rd_ptr];
    assign io_bus.pc_next = r_slot_pc[r_rd_ptr] + XLEN'(4);

    assign w_grant = io_bus.mem_req && io_bus.i_mem_gnt;
    assign w_pop   = io_bus.valid && io_bus.i_ready;
    assign w_drop  = io_bus.i_mem_rvalid && (r_discard != '0);
    assign w_fill  = io_bus.i_mem_rvalid && (r_discard == '0)
                  && (r_pend_cnt != '0) && !io_bus.i_b_taken;

    // A response during a redirect retires one older in-flight request.
    assign w_charge = io_bus.i_mem_rvalid
                   && ((r_discard != '0) || (r_pend_cnt != '0));
    assign w_redir_disc = r_discard + r_pend_cnt - CW'(w_charge);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fetch_pc    <= RESET_PC;
            r_alloc_ptr   <= '0;
            r_fill_ptr    <= '0;
            r_rd_ptr      <= '0;
            r_alloc_cnt   <= '0;
            r_pend_cnt    <= '0;
            r_discard     <= '0;
            r_slot_filled <= '0;
        end else if (io_bus.i_b_taken) begin
            r_fetch_pc    <= {io_bus.i_b_pc[XLEN-1:2], 2'b00};
            r_alloc_ptr   <= '0;
            r_fill_ptr    <= '0;
            r_rd_ptr      <= '0;
            r_alloc_cnt   <= '0;
            r_pend_cnt    <= '0;
            r_discard     <= w_redir_disc;
            r_slot_filled <= '0;
        end else begin
            if (w_grant) begin
                r_slot_pc[r_alloc_ptr]     <= r_fetch_pc;
                r_slot_filled[r_alloc_ptr] <= 1'b0;
                r_alloc_ptr <= r_alloc_ptr + ptr_t'(1);
                r_fetch_pc  <= r_fetch_pc + XLEN'(4);
            end
            if (w_fill) begin
                r_slot_inst[r_fill_ptr]   <= io_bus.i_val_from_mem_ctr;
                r_slot_filled[r_fill_ptr] <= 1'b1;
                r_fill_ptr <= r_fill_ptr + ptr_t'(1);
            end
            if (w_drop) begin
                r_discard <= r_discard - cnt_t'(1);
            end
            if (w_pop) begin
                r_slot_filled[r_rd_ptr] <= 1'b0;
                r_rd_ptr <= r_rd_ptr + ptr_t'(1);
            end
            r_alloc_cnt <= r_alloc_cnt + cnt_t'(w_grant) - cnt_t'(w_pop);
            r_pend_cnt  <= r_pend_cnt + cnt_t'(w_grant) - cnt_t'(w_fill);
        end
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameters: XLEN, default 32, PC/address width; RESET_PC, default 32'h0, first fetch address; DEPTH, default 4, fetch-buffer slots, power of two, minimum 2.
REQ-002 SHALL have ports (one clock; reset is synchronous and active-high):
  i_clk  in  1  clock, all state on rising edge
  i_rst  in  1  synchronous active-high reset
  i_b_taken  in  1  redirect request
  i_b_pc  in  XLEN  redirect target
  mem_req  out  1  instruction-memory request valid
  mem_addr  out  XLEN  request address
  i_mem_gnt  in  1  request accepted when mem_req and i_mem_gnt are both high
  i_mem_rvalid  in  1  response valid; responses return in grant order
  i_val_from_mem_ctr  in  32  response instruction word
  valid  out  1  head entry available
  i_ready  in  1  downstream accepts head
  pc  out  XLEN  PC of head entry
  inst  out  32  instruction of head entry
  pc_next  out  XLEN  pc + 4 of head entry, modulo 2^XLEN

Function
REQ-003 SHALL hold fetch_pc, reset to RESET_PC; mem_addr SHALL equal fetch_pc.
REQ-004 SHALL implement a DEPTH-slot circular buffer with alloc, fill and read pointers; each slot holds pc, inst and a filled flag.
REQ-005 SHALL drive mem_req high iff not i_rst, not i_b_taken, and (allocated + discard_cnt) < DEPTH, using registered counts only; there is no combinational path from i_ready to mem_req.
REQ-006 On grant: allocate the slot at the alloc pointer with pc = fetch_pc and filled = 0; fetch_pc <= fetch_pc + 4, wrapping modulo 2^XLEN.
REQ-007 On i_mem_rvalid with discard_cnt > 0: drop the data and decrement discard_cnt.
REQ-008 On i_mem_rvalid with discard_cnt = 0 and an unfilled allocated slot: write inst to the slot at the fill pointer and set filled; the entry becomes visible on valid the following cycle.
REQ-009 On i_mem_rvalid with nothing outstanding and discard_cnt = 0: ignore the response; no state change.
REQ-010 valid SHALL be high iff the head slot is allocated and filled and i_b_taken is low.
REQ-011 pc and inst SHALL show the head slot whenever valid is high.
REQ-012 A pop occurs on valid and i_ready; the freed slot counts toward mem_req from the next cycle.
REQ-013 Redirect (i_b_taken = 1) SHALL do all of the following:
  - set fetch_pc <= {i_b_pc[XLEN-1:2], 2'b00};
  - clear all slots and pointers;
  - set discard_cnt <= discard_cnt + (granted-but-unfilled slots), minus 1 if a response arrives that cycle and is charged to those slots;
  - suppress pop and grant that cycle.
REQ-014 Redirect overrides any simultaneous grant, response fill or pop; a response in the redirect cycle is always dropped.
REQ-015 Full (allocated + discard_cnt = DEPTH): mem_req low; a simultaneous pop does not raise mem_req in the same cycle.
REQ-016 Empty buffer: valid low; i_ready ignored.
REQ-017 Minimum latency: grant in cycle N, response in cycle N+1, valid in cycle N+2. A response in the same cycle as its own grant is a protocol violation and is unsupported.
REQ-018 discard_cnt SHALL be clog2(DEPTH)+1 bits wide and never exceed DEPTH.

Reset
REQ-019 While i_rst is high: fetch_pc = RESET_PC, pointers and discard_cnt zero, all filled flags clear, mem_req = 0, valid = 0.
REQ-020 Reset mid-operation drops in-flight requests without discard tracking; the memory side is reset together with this block.
REQ-021 The first cycle after reset: mem_req = 1, mem_addr = RESET_PC.

Verification
REQ-022 Streaming (RESET_PC = 0, gnt always 1, 1-cycle response, i_ready = 1):
  - stimulus: reset released, then free-running;
  - response: pc sequence 0, 4, 8, 12 on consecutive cycles from cycle 2; pc_next = pc + 4.
REQ-023 Backpressure fill (i_ready = 0, DEPTH = 4):
  - stimulus: exactly 4 grants, then hold i_ready low;
  - response: mem_req low while full; i_ready = 1 for one cycle, then mem_req returns the next cycle at addr 0x10.
REQ-024 Redirect with 2 outstanding:
  - stimulus: i_b_taken = 1, i_b_pc = 0x103;
  - response: next mem_addr = 0x100; the next 2 responses are dropped; the first valid shows pc = 0x100.
REQ-025 Redirect plus response same cycle:
  - stimulus: i_b_taken and i_mem_rvalid together with 1 outstanding;
  - response: discard_cnt = 0; the next response fills a slot with pc = target.
REQ-026 Wrap (XLEN = 32, RESET_PC = 0xFFFFFFFC):
  - stimulus: two grants;
  - response: mem_addr sequence 0xFFFFFFFC then 0x0; head pc_next = 0x0.
